sdu_uart_rx: RTL

- UART receiver (8N1) that feeds the serial debug unit's command parser from the board `rxd` pin.
- Synchronises and 16x-oversamples `rxd`, majority-votes each bit, and checks the stop bit.
- Buffers received bytes in a small FIFO exposed through a valid/ready handshake.
- Reports framing errors and overflow as single-cycle pulses.

---
 rtl/sdu_uart_rx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sdu_uart_rx.sv
// UART 8N1 receiver: 2-flop synchronised, 16x oversampled, majority-voted bits, small byte FIFO.
// Latency: 2 clocks of synchronisation; dout_vld rises the cycle after the stop bit resolves.
// Backpressure: dout_vld/dout_rdy handshake; a byte arriving into a full FIFO is dropped with an overflow pulse.
module sdu_uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       dout_vld,
    input  logic       dout_rdy,
    output logic       frame_err,
    output logic       overflow
);

    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic          sync1_q, sync2_q, hist_q;
    logic [DW-1:0] div_q;
    state_t        state_q;
    logic [3:0]    samp_q;
    logic          v7_q, v8_q;
    logic [2:0]    idx_q;
    logic [7:0]    shreg_q;
    logic          frame_err_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    dout_q;
    logic          ovf_q;

    logic tick, start_edge, resolve, bit_val;
    logic push, pop, push_acc, full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign tick       = (div_q == DIV_LAST);
    assign start_edge = (state_q == ST_IDLE) && hist_q && !sync2_q;
    assign resolve    = tick && (samp_q == 4'd9);
    // Third vote is the live sample taken on tick 9 itself.
    assign bit_val    = (v7_q & v8_q) | (v7_q & sync2_q) | (v8_q & sync2_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q <= '0;
        end else if (start_edge || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            samp_q      <= '0;
            v7_q        <= 1'b0;
            v8_q        <= 1'b0;
            idx_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (state_q != ST_IDLE && tick) begin
                samp_q <= samp_q + 4'd1;
                if (samp_q == 4'd7) v7_q <= sync2_q;
                if (samp_q == 4'd8) v8_q <= sync2_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_q <= ST_START;
                        samp_q  <= '0;
                    end
                end
                ST_START: begin
                    if (resolve) begin
                        if (!bit_val) begin
                            state_q <= ST_DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (resolve) begin
                        shreg_q[idx_q] <= bit_val;
                        if (idx_q == 3'd7) state_q <= ST_STOP;
                        else               idx_q   <= idx_q + 3'd1;
                    end
                end
                ST_STOP: begin
                    if (resolve) begin
                        if (bit_val) begin
                            state_q <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (sync2_q) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign push     = (state_q == ST_STOP) && resolve && bit_val;
    assign full     = (cnt_q == CNT_FULL);
    assign pop      = (cnt_q != '0) && dout_rdy;
    assign push_acc = push && (!full || pop);

    always_comb begin
        rd_d  = pop ? rd_q + PTR_ONE : rd_q;
        cnt_d = cnt_q;
        if (push_acc && !pop)      cnt_d = cnt_q + CNT_ONE;
        else if (!push_acc && pop) cnt_d = cnt_q - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_acc) begin
                mem_q[wr_q] <= shreg_q;
                wr_q        <= wr_q + PTR_ONE;
            end
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= push && full && !pop;
            // Head register follows the next head slot, bypassing a same-cycle write into it.
            if (cnt_d != '0) begin
                dout_q <= (push_acc && (wr_q == rd_d)) ? shreg_q : mem_q[rd_d];
            end
        end
    end

    assign dout      = dout_q;
    assign dout_vld  = (cnt_q != '0);
    assign frame_err = frame_err_q;
    assign overflow  = ovf_q;

endmodule
